// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scan driver with dead time, blink and frame strobe
// Define SEG7_DIM_EN to add the dim[3:0] PWM brightness input.
module seg7_scan_mux #(
    parameter int NDIG         = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
`ifdef SEG7_DIM_EN
    input  logic [3:0]          dim,
`endif
    input  logic [7*NDIG-1:0]   seg_in,
    input  logic [NDIG-1:0]     dp_mask,
    input  logic [NDIG-1:0]     blink_mask,
    output logic [6:0]          seg_out,
    output logic                dp_out,
    output logic [NDIG-1:0]     dig_sel,
    output logic                frame_tick
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;
    logic              run_q, run_d;
    logic [7*NDIG-1:0] shadow_q, shadow_d;
    logic [NDIG-1:0]   dp_shadow_q, dp_shadow_d;
    logic [6:0]        seg_out_q, seg_out_d;
    logic              dp_out_q, dp_out_d;
    logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
    logic              frame_tick_q, frame_tick_d;
`ifdef SEG7_DIM_EN
    logic [3:0]        pwm_q, pwm_d;
`endif

    logic              slot_end, frame_end, lit;
    logic [6:0]        cur_seg;
    logic              cur_dp, cur_blink;
    logic [NDIG-1:0]   cur_sel;

    always_comb begin
        cur_seg   = 7'h7F;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_sel   = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_seg    = shadow_q[7*(NDIG-i)-1 -: 7];
                cur_dp     = dp_shadow_q[i];
                cur_blink  = blink_mask[i];
                cur_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        slot_end     = (pre_q == PRE_LAST);
        frame_end    = slot_end && (idx_q == IDX_LAST);
        pre_d        = '0;
        idx_d        = '0;
        blink_cnt_d  = '0;
        blink_ph_d   = blink_ph_q;
        run_d        = 1'b0;
        shadow_d     = shadow_q;
        dp_shadow_d  = dp_shadow_q;
        seg_out_d    = 7'h7F;
        dp_out_d     = 1'b1;
        dig_sel_d    = '1;
        frame_tick_d = 1'b0;
        lit          = 1'b0;
`ifdef SEG7_DIM_EN
        pwm_d        = pwm_q + 4'd1;
`endif
        if (en) begin
            run_d        = 1'b1;
            pre_d        = slot_end ? '0 : pre_q + 1'b1;
            idx_d        = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
            blink_cnt_d  = blink_cnt_q;
            frame_tick_d = frame_end;
            // Shadow reloads on scan entry and at each frame wrap so a frame never mixes two times.
            if (!run_q || frame_end) begin
                shadow_d    = seg_in;
                dp_shadow_d = dp_mask;
            end
            if (frame_end) begin
                if (blink_cnt_q == BLK_LAST) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            lit = (pre_q >= PRE_BLANK) && !(blink_ph_q && cur_blink);
`ifdef SEG7_DIM_EN
            lit = lit && (pwm_q < dim);
`endif
            if (lit) begin
                seg_out_d = cur_seg;
                dp_out_d  = ~cur_dp;
                dig_sel_d = cur_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q        <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            run_q        <= 1'b0;
            shadow_q     <= {NDIG{7'h7F}};
            dp_shadow_q  <= '0;
            seg_out_q    <= 7'h7F;
            dp_out_q     <= 1'b1;
            dig_sel_q    <= '1;
            frame_tick_q <= 1'b0;
`ifdef SEG7_DIM_EN
            pwm_q        <= 4'd0;
`endif
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            run_q        <= run_d;
            shadow_q     <= shadow_d;
            dp_shadow_q  <= dp_shadow_d;
            seg_out_q    <= seg_out_d;
            dp_out_q     <= dp_out_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG7_DIM_EN
            pwm_q        <= pwm_d;
`endif
        end
    end

    assign seg_out    = seg_out_q;
    assign dp_out     = dp_out_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - scoreboard bench for seg7_scan_mux (NDIG=6, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
module tb_seg7_scan_mux;

    localparam int NDIG         = 6;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = NDIG * SCAN_DIV;

    localparam logic [7*NDIG-1:0] DIGITS_123456 = {7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20};

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic [7*NDIG-1:0]   seg_in;
    logic [NDIG-1:0]     dp_mask;
    logic [NDIG-1:0]     blink_mask;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [NDIG-1:0]     dig_sel;
    logic                frame_tick;
`ifdef SEG7_DIM_EN
    logic [3:0]          dim;
`endif

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
`ifdef SEG7_DIM_EN
        .dim(dim),
`endif
        .seg_in(seg_in),
        .dp_mask(dp_mask),
        .blink_mask(blink_mask),
        .seg_out(seg_out),
        .dp_out(dp_out),
        .dig_sel(dig_sel),
        .frame_tick(frame_tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: one time counter within the frame, digit/slot derived by division.
    int              m_t;
    bit              m_run;
    logic [6:0]      m_sh [NDIG];
    logic [NDIG-1:0] m_dp;
    bit              m_bph;
    int              m_bcnt;
    logic [3:0]      m_pwm;
    int              last_t;
    int              cyc = 0;
    logic [14:0]     exp_q [$];
    int              ft_times [$];

    function automatic logic [NDIG-1:0] sel_of(input int i);
        logic [NDIG-1:0] v;
        v    = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        logic [14:0] e;
        int          pre, dig;
        bit          lit, ft;
        e = {1'b0, 1'b1, {NDIG{1'b1}}, 7'h7F};
        if (reset) begin
            m_t = 0; m_run = 0; m_bcnt = 0; m_bph = 0; m_dp = '0; last_t = -1;
            for (int i = 0; i < NDIG; i++) m_sh[i] = 7'h7F;
        end else if (!en) begin
            m_t = 0; m_run = 0; m_bcnt = 0; last_t = -1;
        end else begin
            pre = m_t % SCAN_DIV;
            dig = m_t / SCAN_DIV;
            ft  = (m_t == FRAME - 1);
            lit = (pre >= BLANK_CYC) && !(m_bph && blink_mask[dig]);
`ifdef SEG7_DIM_EN
            lit = lit && (m_pwm < dim);
`endif
            if (lit) e = {ft, ~m_dp[dig], sel_of(dig), m_sh[dig]};
            else     e = {ft, 1'b1, {NDIG{1'b1}}, 7'h7F};
            if (!m_run || ft) begin
                for (int i = 0; i < NDIG; i++) m_sh[i] = seg_in[7*(NDIG-i)-1 -: 7];
                m_dp = dp_mask;
            end
            if (ft) begin
                m_bcnt++;
                if (m_bcnt == BLINK_FRAMES) begin
                    m_bcnt = 0;
                    m_bph  = !m_bph;
                end
            end
            last_t = m_t;
            m_t    = (m_t + 1) % FRAME;
            m_run  = 1;
        end
        m_pwm = reset ? 4'd0 : m_pwm + 4'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check($sformatf("out t=%0d {ft,dp,sel,seg}", last_t),
              {17'd0, frame_tick, dp_out, dig_sel, seg_out}, {17'd0, e});
        if (frame_tick) ft_times.push_back(cyc);
    endtask

    task automatic run_to(input int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (last_t != t && n < 2 * FRAME);
    endtask

    initial begin
        int restart_cyc, n;
        reset      = 1'b1;
        en         = 1'b1;
        seg_in     = DIGITS_123456;
        dp_mask    = '0;
        blink_mask = '0;
`ifdef SEG7_DIM_EN
        dim        = 4'hF;
`endif
        repeat (3) tick();
        check("rst_seg", {25'd0, seg_out}, 32'h7F);
        check("rst_dig", {26'd0, dig_sel}, 32'h3F);
        check("rst_dp",  {31'd0, dp_out}, 32'd1);
        check("rst_ft",  {31'd0, frame_tick}, 32'd0);

        // Normal scan of "123456" from reset release.
        reset = 1'b0;
        ft_times.delete();
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (k == 1) check("d0_dead", {26'd0, dig_sel}, 32'h3F);
            if (k == 2) begin
                check("d0_sel", {26'd0, dig_sel}, 32'b111110);
                check("d0_seg", {25'd0, seg_out}, 32'h4F);
            end
            if (k == FRAME - 1) begin
                check("d5_sel", {26'd0, dig_sel}, 32'b011111);
                check("d5_seg", {25'd0, seg_out}, 32'h20);
            end
        end
        check("ft_count", ft_times.size(), 2);
        check("ft_first", (ft_times.size() > 0) ? ft_times[0] : 0, FRAME + 3);
        check("ft_period", (ft_times.size() > 1) ? ft_times[1] - ft_times[0] : 0, FRAME);

        // Mid-frame seg_in change only shows after the next frame wrap.
        run_to(19);
        seg_in = {NDIG{7'h01}};
        run_to(26);
        check("old_d3", {25'd0, seg_out}, 32'h4C);
        run_to(42);
        check("old_d5", {25'd0, seg_out}, 32'h20);
        run_to(2);
        check("new_d0", {25'd0, seg_out}, 32'h01);
        run_to(FRAME - 1);

        // Blink and decimal point.
        seg_in     = DIGITS_123456;
        blink_mask = 6'b110000;
        dp_mask    = 6'b000100;
        for (int f = 0; f < 6; f++) begin
            run_to(34);
            check($sformatf("blink4_f%0d", f), {26'd0, dig_sel}, m_bph ? 32'h3F : 32'b101111);
            run_to(2);
            check($sformatf("noblink0_f%0d", f), {26'd0, dig_sel}, 32'b111110);
        end
        run_to(18);
        check("dp_d2", {31'd0, dp_out}, 32'd0);
        run_to(26);
        check("dp_d3", {31'd0, dp_out}, 32'd1);

        // en dropped mid digit 3, restored after 5 cycles.
        blink_mask = '0;
        run_to(27);
        en = 1'b0;
        tick();
        check("en0_sel", {26'd0, dig_sel}, 32'h3F);
        check("en0_seg", {25'd0, seg_out}, 32'h7F);
        repeat (4) tick();
        en          = 1'b1;
        restart_cyc = cyc;
        run_to(2);
        check("restart_sel", {26'd0, dig_sel}, 32'b111110);
        n = 0;
        while (!frame_tick && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("restart_ft", cyc - restart_cyc, FRAME);

        // Reset mid-slot.
        run_to(35);
        reset = 1'b1;
        tick();
        check("rst_mid_sel", {26'd0, dig_sel}, 32'h3F);
        reset = 1'b0;
        run_to(2);
        check("rst_mid_restart", {26'd0, dig_sel}, 32'b111110);

        // Random traffic against the scoreboard.
        for (int k = 0; k < 4 * FRAME; k++) begin
            if ($urandom_range(0, 7) == 0) seg_in = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) blink_mask = NDIG'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = NDIG'($urandom);
            en = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
